// File: rtl/ifmap_write_controller.sv
// Write end of the IFMap circular scratchpad: pulls words from the input FIFO,
// writes them at the wrapping write pointer, and tracks occupancy and row boundaries.
module ifmap_write_controller #(
  parameter int POINTER_SIZE = 8,
  parameter int IFMAP_SIZE   = 16,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [POINTER_SIZE-1:0] row_len_i,
  input  logic [POINTER_SIZE-1:0] num_rows_i,
  input  logic                    in_valid_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  output logic                    in_ready_o,
  input  logic                    release_i,
  input  logic [POINTER_SIZE-1:0] release_cnt_i,
  output logic                    wr_en_o,
  output logic [POINTER_SIZE-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic [POINTER_SIZE-1:0] write_pointer_o,
  output logic [POINTER_SIZE-1:0] len_counter_o,
  output logic                    row_end_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    underflow_err_o
);

  localparam logic [POINTER_SIZE-1:0] DEPTH = POINTER_SIZE'(IFMAP_SIZE);
  localparam logic [POINTER_SIZE-1:0] LAST  = POINTER_SIZE'(IFMAP_SIZE - 1);
  localparam logic [POINTER_SIZE-1:0] ONE   = POINTER_SIZE'(1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e state_q, state_d;

  logic [POINTER_SIZE-1:0] row_len_q, row_len_d;
  logic [POINTER_SIZE-1:0] num_rows_q, num_rows_d;
  logic [POINTER_SIZE-1:0] col_q, col_d;
  logic [POINTER_SIZE-1:0] row_q, row_d;
  logic [POINTER_SIZE-1:0] wp_q, wp_d;
  logic [POINTER_SIZE-1:0] len_q, len_d;
  logic                    uf_q, uf_d;

  logic                    accept;
  logic                    last_col;
  logic                    last_row;
  logic [POINTER_SIZE:0]   len_sum;
  logic [POINTER_SIZE:0]   rel_amt;

  assign accept   = in_valid_i && in_ready_o;
  assign last_col = (col_q == row_len_q - ONE);
  assign last_row = (row_q == num_rows_q - ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (row_len_i == '0 || num_rows_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (row_end_o && last_row) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == FILL);
    done_o     = (state_q == DONE);
    in_ready_o = (state_q == FILL) && (len_q < DEPTH);
    wr_en_o    = accept;
    row_end_o  = accept && last_col;
  end

  assign wr_addr_o       = wp_q;
  assign wr_data_o       = in_data_i;
  assign write_pointer_o = wp_q;
  assign len_counter_o   = len_q;
  assign underflow_err_o = uf_q;

  // Occupancy is evaluated one bit wider so an over-release is detected and saturated.
  always_comb begin
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    col_d      = col_q;
    row_d      = row_q;
    wp_d       = wp_q;
    uf_d       = uf_q;
    len_sum    = {1'b0, len_q} + {{POINTER_SIZE{1'b0}}, accept};
    rel_amt    = release_i ? {1'b0, release_cnt_i} : '0;

    if (rel_amt > len_sum) begin
      len_d = '0;
      uf_d  = 1'b1;
    end else begin
      len_d = POINTER_SIZE'(len_sum - rel_amt);
    end

    if (state_q == IDLE && start_i) begin
      row_len_d  = row_len_i;
      num_rows_d = num_rows_i;
      col_d      = '0;
      row_d      = '0;
    end

    if (accept) begin
      wp_d = (wp_q == LAST) ? '0 : wp_q + ONE;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_len_q  <= '0;
      num_rows_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wp_q       <= '0;
      len_q      <= '0;
      uf_q       <= 1'b0;
    end else begin
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wp_q       <= wp_d;
      len_q      <= len_d;
      uf_q       <= uf_d;
    end
  end

endmodule

// File: tb/tb_ifmap_write_controller.sv
// Self-checking bench for ifmap_write_controller: a vector table for the basic
// two-row transfer plus hand-written sequences for full, wrap, release and reset cases.
module tb_ifmap_write_controller;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [7:0]  rowLen;
  logic [7:0]  numRows;
  logic        inValid;
  logic [15:0] inData;
  logic        inReady;
  logic        rel;
  logic [7:0]  relCnt;
  logic        wrEn;
  logic [7:0]  wrAddr;
  logic [15:0] wrData;
  logic [7:0]  writePointer;
  logic [7:0]  lenCounter;
  logic        rowEnd;
  logic        busy;
  logic        done;
  logic        underflowErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       inValid;
    logic       expWrEn;
    logic [7:0] expAddr;
    logic       expRowEnd;
    logic       expDone;
    logic [7:0] expLen;
  } vec_t;

  vec_t vecs[10];

  ifmap_write_controller #(
    .POINTER_SIZE(8),
    .IFMAP_SIZE  (16),
    .DATA_WIDTH  (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .start_i        (start),
    .row_len_i      (rowLen),
    .num_rows_i     (numRows),
    .in_valid_i     (inValid),
    .in_data_i      (inData),
    .in_ready_o     (inReady),
    .release_i      (rel),
    .release_cnt_i  (relCnt),
    .wr_en_o        (wrEn),
    .wr_addr_o      (wrAddr),
    .wr_data_o      (wrData),
    .write_pointer_o(writePointer),
    .len_counter_o  (lenCounter),
    .row_end_o      (rowEnd),
    .busy_o         (busy),
    .done_o         (done),
    .underflow_err_o(underflowErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r, input logic [7:0] rc);
    inValid = v;
    inData  = d;
    rel     = r;
    relCnt  = rc;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic eWrEn, input logic [7:0] eAddr,
                            input logic eRowEnd, input logic eDone, input logic [7:0] eLen);
    checkOutput({tag, " wr_en"}, 32'(wrEn), 32'(eWrEn));
    if (eWrEn) begin
      checkOutput({tag, " wr_addr"}, 32'(wrAddr), 32'(eAddr));
      checkOutput({tag, " wr_data"}, 32'(wrData), 32'(inData));
    end
    checkOutput({tag, " row_end"}, 32'(rowEnd), 32'(eRowEnd));
    checkOutput({tag, " done"}, 32'(done), 32'(eDone));
    checkOutput({tag, " len_counter"}, 32'(lenCounter), 32'(eLen));
  endtask

  task automatic startTransfer(input logic [7:0] rl, input logic [7:0] nr);
    start   = 1'b1;
    rowLen  = rl;
    numRows = nr;
    nextCycle();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] t3Len[8];

    // Basic 4x2 transfer, one row per four cycles, then DONE and IDLE.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b1, 8'(i), (i == 3 || i == 7), 1'b0, 8'(i)};
    end
    vecs[8] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd8};
    vecs[9] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd8};
    t3Len = '{8'd8, 8'd9, 8'd10, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};

    rstN = 1'b0; start = 1'b0; rowLen = '0; numRows = '0;
    applyStimulus(1'b0, 16'h0, 1'b0, 8'd0);
    #12;
    checkOutput("reset in_ready", 32'(inReady), 32'd0);
    checkOutput("reset wr_en", 32'(wrEn), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset underflow", 32'(underflowErr), 32'd0);
    checkOutput("reset len", 32'(lenCounter), 32'd0);
    checkOutput("reset wp", 32'(writePointer), 32'd0);
    rstN = 1'b1;
    nextCycle();

    $display("[TB] test 1: row_len=4 num_rows=2");
    applyStimulus(1'b1, 16'hA000, 1'b0, 8'd0);
    startTransfer(8'd4, 8'd2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].inValid, 16'hA000 + 16'(i), 1'b0, 8'd0);
      checkCycle($sformatf("t1[%0d]", i), vecs[i].expWrEn, vecs[i].expAddr,
                 vecs[i].expRowEnd, vecs[i].expDone, vecs[i].expLen);
      if (i < 8) checkOutput($sformatf("t1[%0d] busy", i), 32'(busy), 32'd1);
      nextCycle();
    end
    checkOutput("t1 write_pointer", 32'(writePointer), 32'd8);

    $display("[TB] test 3: accept and release together, pointer wrap");
    startTransfer(8'd4, 8'd2);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 16'hB000 + 16'(k), (k == 2), (k == 2) ? 8'd3 : 8'd0);
      checkCycle($sformatf("t3[%0d]", k), 1'b1, 8'(8 + k), (k == 3 || k == 7), 1'b0, t3Len[k]);
      nextCycle();
    end
    applyStimulus(1'b1, 16'h0, 1'b0, 8'd0);
    checkCycle("t3 done", 1'b0, 8'd0, 1'b0, 1'b1, 8'd13);
    checkOutput("t3 wrap wp", 32'(writePointer), 32'd0);
    nextCycle();

    $display("[TB] test 4: over-release underflow");
    applyStimulus(1'b0, 16'h0, 1'b1, 8'd11);
    nextCycle();
    checkOutput("t4 len after release 11", 32'(lenCounter), 32'd2);
    checkOutput("t4 no underflow yet", 32'(underflowErr), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 8'd5);
    nextCycle();
    applyStimulus(1'b0, 16'h0, 1'b0, 8'd0);
    checkOutput("t4 len saturates", 32'(lenCounter), 32'd0);
    checkOutput("t4 underflow set", 32'(underflowErr), 32'd1);

    $display("[TB] test 2: full stall, release, wrap");
    applyStimulus(1'b1, 16'hC000, 1'b0, 8'd0);
    startTransfer(8'd16, 8'd2);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 16'hC000 + 16'(k), 1'b0, 8'd0);
      checkCycle($sformatf("t2a[%0d]", k), 1'b1, 8'(k), (k == 15), 1'b0, 8'(k));
      nextCycle();
    end
    for (int s = 0; s < 2; s++) begin
      applyStimulus(1'b1, 16'hCCCC, (s == 1), (s == 1) ? 8'd16 : 8'd0);
      checkOutput($sformatf("t2 stall[%0d] in_ready", s), 32'(inReady), 32'd0);
      checkOutput($sformatf("t2 stall[%0d] wr_en", s), 32'(wrEn), 32'd0);
      checkOutput($sformatf("t2 stall[%0d] len", s), 32'(lenCounter), 32'd16);
      checkOutput($sformatf("t2 stall[%0d] busy", s), 32'(busy), 32'd1);
      nextCycle();
    end
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 16'hD000 + 16'(k), 1'b0, 8'd0);
      if (k == 0) checkOutput("t2 in_ready after release", 32'(inReady), 32'd1);
      checkCycle($sformatf("t2b[%0d]", k), 1'b1, 8'(k), (k == 15), 1'b0, 8'(k));
      nextCycle();
    end
    checkCycle("t2 done", 1'b0, 8'd0, 1'b0, 1'b1, 8'd16);
    checkOutput("t2 underflow sticky", 32'(underflowErr), 32'd1);
    nextCycle();

    $display("[TB] test 6: zero rows, start while busy");
    applyStimulus(1'b1, 16'hE000, 1'b0, 8'd0);
    start = 1'b1; rowLen = 8'd4; numRows = 8'd0;
    #1;
    checkOutput("t6 start cycle wr_en", 32'(wrEn), 32'd0);
    nextCycle();
    start = 1'b0;
    checkCycle("t6 zero-row done", 1'b0, 8'd0, 1'b0, 1'b1, 8'd16);
    nextCycle();
    checkCycle("t6 back idle", 1'b0, 8'd0, 1'b0, 1'b0, 8'd16);
    applyStimulus(1'b0, 16'h0, 1'b1, 8'd16);
    nextCycle();
    applyStimulus(1'b0, 16'h0, 1'b0, 8'd0);
    startTransfer(8'd2, 8'd1);
    start = 1'b1; rowLen = 8'd5; numRows = 8'd3;
    nextCycle();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'hE100 + 16'(k), 1'b0, 8'd0);
      checkCycle($sformatf("t6 busy start[%0d]", k), (k < 2), 8'(k), (k == 1), (k == 2), 8'(k));
      nextCycle();
    end

    $display("[TB] test 5: asynchronous reset mid-row");
    startTransfer(8'd8, 8'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'hF000 + 16'(k), 1'b0, 8'd0);
      checkCycle($sformatf("t5[%0d]", k), 1'b1, 8'(2 + k), 1'b0, 1'b0, 8'(2 + k));
      nextCycle();
    end
    rstN = 1'b0;
    #1;
    checkOutput("t5 async wr_en", 32'(wrEn), 32'd0);
    checkOutput("t5 async in_ready", 32'(inReady), 32'd0);
    checkOutput("t5 async busy", 32'(busy), 32'd0);
    checkOutput("t5 async wp", 32'(writePointer), 32'd0);
    checkOutput("t5 async len", 32'(lenCounter), 32'd0);
    checkOutput("t5 async row_end", 32'(rowEnd), 32'd0);
    checkOutput("t5 async underflow", 32'(underflowErr), 32'd0);
    #3;
    rstN = 1'b1;
    nextCycle();
    startTransfer(8'd2, 8'd1);
    checkCycle("t5 restart", 1'b1, 8'd0, 1'b0, 1'b0, 8'd0);
    nextCycle();
    checkCycle("t5 restart row end", 1'b1, 8'd1, 1'b1, 1'b0, 8'd1);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
